// File: rtl/morra_cinese_param_if.sv
// Move/result bundle between the player decoders, the match controller
// and the display/scoreboard logic.
interface morra_cinese_param_if #(
    parameter int CNT_W = 5
);
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic             INIZIA;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic [CNT_W-1:0] PT1;
    logic [CNT_W-1:0] PT2;
    logic [CNT_W-1:0] ROUND;
    logic             BUSY;

    modport master (
        output PRIMO, SECONDO, INIZIA,
        input  MANCHE, PARTITA, PT1, PT2, ROUND, BUSY
    );

    modport slave (
        input  PRIMO, SECONDO, INIZIA,
        output MANCHE, PARTITA, PT1, PT2, ROUND, BUSY
    );
endinterface

// File: rtl/morra_cinese_param.sv
// Parametrised rock-paper-scissors match controller: IDLE/PLAY/OVER FSM,
// per-manche scoring, optional repeat-ban on the last winning move, and
// early (margin) or full-length match termination.
module morra_cinese_param #(
    parameter int MAX_BASE   = 4,
    parameter int MIN_ROUNDS = 4,
    parameter int WIN_MARGIN = 2,
    parameter int CNT_W      = 5,
    parameter int BAN_EN     = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    morra_cinese_param_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    localparam logic [CNT_W-1:0]   BASE  = CNT_W'(MAX_BASE);
    localparam logic [CNT_W-1:0]   MIN_R = CNT_W'(MIN_ROUNDS);
    localparam logic signed [CNT_W:0] MARG = (CNT_W+1)'(WIN_MARGIN);

    state_t           state;
    logic [CNT_W-1:0] max_r, pt1_q, pt2_q, round_q;
    logic [1:0]       ban1, ban2, manche_q, partita_q;
    logic             busy_q;

    logic             invalid, draw, p1_wins;
    logic [CNT_W-1:0] pt1_n, pt2_n, round_n;
    logic signed [CNT_W:0] diff;
    logic             margin_end, max_end;
    logic [1:0]       leader;

    // Score the current moves against the current counts; used only on a
    // valid manche in PLAY.
    always_comb begin
        p1_wins = (bus.PRIMO == 2'b01 && bus.SECONDO == 2'b11) ||
                  (bus.PRIMO == 2'b10 && bus.SECONDO == 2'b01) ||
                  (bus.PRIMO == 2'b11 && bus.SECONDO == 2'b10);
        draw    = (bus.PRIMO == bus.SECONDO);
        // A ban value of 00 never matches a legal move, so no separate
        // "ban active" flag is needed.
        invalid = (bus.PRIMO == 2'b00) || (bus.SECONDO == 2'b00) ||
                  ((BAN_EN != 0) && ((bus.PRIMO == ban1) || (bus.SECONDO == ban2)));
        pt1_n   = pt1_q;
        pt2_n   = pt2_q;
        round_n = round_q + 1'b1;
        if (!draw) begin
            if (p1_wins) pt1_n = pt1_q + 1'b1;
            else         pt2_n = pt2_q + 1'b1;
        end
        diff       = $signed({1'b0, pt1_n}) - $signed({1'b0, pt2_n});
        margin_end = (round_n >= MIN_R) && ((diff >= MARG) || (diff <= -MARG));
        max_end    = (round_n == max_r);
        if (pt1_n > pt2_n)      leader = 2'b01;
        else if (pt2_n > pt1_n) leader = 2'b10;
        else                    leader = 2'b11;
    end

    // Match FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            max_r     <= '0;
            pt1_q     <= '0;
            pt2_q     <= '0;
            round_q   <= '0;
            ban1      <= 2'b00;
            ban2      <= 2'b00;
            manche_q  <= 2'b00;
            partita_q <= 2'b00;
            busy_q    <= 1'b0;
        end else if (bus.INIZIA) begin
            // Start/restart wins over any manche on this edge.
            state     <= S_PLAY;
            max_r     <= CNT_W'({bus.PRIMO, bus.SECONDO}) + BASE;
            pt1_q     <= '0;
            pt2_q     <= '0;
            round_q   <= '0;
            ban1      <= 2'b00;
            ban2      <= 2'b00;
            manche_q  <= 2'b00;
            partita_q <= 2'b00;
            busy_q    <= 1'b1;
        end else if (state != S_PLAY || invalid) begin
            manche_q <= 2'b00;
        end else begin
            round_q <= round_n;
            pt1_q   <= pt1_n;
            pt2_q   <= pt2_n;
            if (draw) begin
                manche_q <= 2'b11;
                ban1     <= 2'b00;
                ban2     <= 2'b00;
            end else if (p1_wins) begin
                manche_q <= 2'b01;
                ban1     <= (BAN_EN != 0) ? bus.PRIMO : 2'b00;
                ban2     <= 2'b00;
            end else begin
                manche_q <= 2'b10;
                ban1     <= 2'b00;
                ban2     <= (BAN_EN != 0) ? bus.SECONDO : 2'b00;
            end
            if (margin_end || max_end) begin
                state     <= S_OVER;
                partita_q <= leader;
                busy_q    <= 1'b0;
            end
        end
    end

    assign bus.MANCHE  = manche_q;
    assign bus.PARTITA = partita_q;
    assign bus.PT1     = pt1_q;
    assign bus.PT2     = pt2_q;
    assign bus.ROUND   = round_q;
    assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed bench for the match controller. Two instances share the move
// inputs: one with the repeat-ban enabled, one with it disabled.
module tb_morra_cinese_param;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] p, s;
    logic ini;

    morra_cinese_param_if #(.CNT_W(5)) ifa ();
    morra_cinese_param_if #(.CNT_W(5)) ifb ();

    assign ifa.PRIMO   = p;
    assign ifa.SECONDO = s;
    assign ifa.INIZIA  = ini;
    assign ifb.PRIMO   = p;
    assign ifb.SECONDO = s;
    assign ifb.INIZIA  = ini;

    morra_cinese_param #(.BAN_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    morra_cinese_param #(.BAN_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] m, pa;
        logic [4:0] p1, p2, r;
        logic       b;
        logic       chkb;
        logic [1:0] mb;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic push(input string nm, input logic [1:0] em, input logic [1:0] ep,
                        input int e1, input int e2, input int er, input logic eb,
                        input logic cb, input logic [1:0] emb);
        exp_t e;
        e.name = nm; e.m = em; e.pa = ep;
        e.p1 = 5'(e1); e.p2 = 5'(e2); e.r = 5'(er);
        e.b = eb; e.chkb = cb; e.mb = emb;
        q.push_back(e);
    endtask

    // Apply one vector for the next rising edge and queue its expectation.
    task automatic step(input string nm, input logic [1:0] pp, input logic [1:0] ss,
                        input logic ii, input logic [1:0] em, input logic [1:0] ep,
                        input int e1, input int e2, input int er, input logic eb,
                        input logic cb, input logic [1:0] emb);
        @(negedge clk);
        p = pp; s = ss; ini = ii;
        push(nm, em, ep, e1, e2, er, eb, cb, emb);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic rst_pulse(input string nm);
        @(negedge clk);
        #2;
        push(nm, 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b0;
        #5;
        rst_n = 1'b1;
    endtask

    // Monitor: outputs change on every clock edge or reset assertion.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (ifa.MANCHE !== e.m || ifa.PARTITA !== e.pa || ifa.PT1 !== e.p1 ||
                ifa.PT2 !== e.p2 || ifa.ROUND !== e.r || ifa.BUSY !== e.b ||
                (e.chkb && ifb.MANCHE !== e.mb)) begin
                n_bad++;
                $display("FAIL %s: got M=%b P=%b PT1=%0d PT2=%0d R=%0d B=%b Mb=%b, want M=%b P=%b PT1=%0d PT2=%0d R=%0d B=%b Mb=%b(chk %b)",
                         e.name, ifa.MANCHE, ifa.PARTITA, ifa.PT1, ifa.PT2, ifa.ROUND,
                         ifa.BUSY, ifb.MANCHE, e.m, e.pa, e.p1, e.p2, e.r, e.b, e.mb, e.chkb);
            end
        end
    end

    initial begin
        p = 2'b00; s = 2'b00; ini = 1'b0;
        rst_n = 1'b0;
        #12 rst_n = 1'b1;

        // Idle after reset, moves ignored
        step("idle0",     0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0);
        step("idle_mv",   1, 3, 0,  0, 0, 0, 0, 0, 0,  0, 0);
        // Early margin win, MAX=4
        step("start4",    0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("w1a",       1, 3, 0,  1, 0, 1, 0, 1, 1,  0, 0);
        step("w1b",       2, 1, 0,  1, 0, 2, 0, 2, 1,  0, 0);
        step("w1c",       3, 2, 0,  1, 0, 3, 0, 3, 1,  0, 0);
        step("early",     1, 2, 0,  2, 1, 3, 1, 4, 0,  0, 0);
        step("over_hold", 1, 3, 0,  0, 1, 3, 1, 4, 0,  0, 0);
        // Restart from OVER with code 1111 (MAX=19), then reset mid-match
        step("restart15", 3, 3, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("d1",        1, 1, 0,  3, 0, 0, 0, 1, 1,  0, 0);
        step("d2",        2, 2, 0,  3, 0, 0, 0, 2, 1,  0, 0);
        step("d3",        3, 3, 0,  3, 0, 0, 0, 3, 1,  0, 0);
        rst_pulse("rst_mid");
        step("post_rst",  1, 3, 0,  0, 0, 0, 0, 0, 0,  0, 0);
        // Repeat-ban, compared against the ban-disabled instance
        step("start_ban", 0, 0, 1,  0, 0, 0, 0, 0, 1,  1, 0);
        step("ban_w1",    1, 3, 0,  1, 0, 1, 0, 1, 1,  1, 1);
        step("ban_blk",   1, 2, 0,  0, 0, 1, 0, 1, 1,  1, 2);
        step("ban_draw",  2, 2, 0,  3, 0, 1, 0, 2, 1,  1, 3);
        step("ban_clr",   1, 3, 0,  1, 0, 2, 0, 3, 1,  1, 1);
        step("max_lead",  2, 3, 0,  2, 1, 2, 1, 4, 0,  1, 0);
        // Full-length draw, MAX=5
        step("start5",    0, 1, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("f_w1",      1, 3, 0,  1, 0, 1, 0, 1, 1,  0, 0);
        step("f_w2",      3, 1, 0,  2, 0, 1, 1, 2, 1,  0, 0);
        step("f_d",       2, 2, 0,  3, 0, 1, 1, 3, 1,  0, 0);
        step("f_w1b",     2, 1, 0,  1, 0, 2, 1, 4, 1,  0, 0);
        step("f_w2b",     1, 2, 0,  2, 3, 2, 2, 5, 0,  0, 0);
        // Full length with margin 1, MAX=4
        step("start4b",   0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("inv00",     0, 1, 0,  0, 0, 0, 0, 0, 1,  0, 0);
        step("m_w1",      1, 3, 0,  1, 0, 1, 0, 1, 1,  0, 0);
        step("m_d1",      2, 2, 0,  3, 0, 1, 0, 2, 1,  0, 0);
        step("m_d2",      3, 3, 0,  3, 0, 1, 0, 3, 1,  0, 0);
        step("m_w2",      1, 2, 0,  2, 3, 1, 1, 4, 0,  0, 0);
        step("m_hold",    1, 2, 0,  0, 3, 1, 1, 4, 0,  0, 0);
        // Variant W1,D,D,D with a restart while in PLAY
        step("start4c",   0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("v_w1",      1, 3, 0,  1, 0, 1, 0, 1, 1,  0, 0);
        step("restart_pl",0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0);
        step("v_w1b",     1, 3, 0,  1, 0, 1, 0, 1, 1,  0, 0);
        step("v_d1",      2, 2, 0,  3, 0, 1, 0, 2, 1,  0, 0);
        step("v_d2",      3, 3, 0,  3, 0, 1, 0, 3, 1,  0, 0);
        step("v_d3",      1, 1, 0,  3, 1, 1, 0, 4, 0,  0, 0);

        @(negedge clk);
        p = 2'b00; s = 2'b00; ini = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
